// File: rtl/fan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fan_ctrl_pkg
// Shared types and helpers for the fan PID step engine: FSM state encoding,
// difference-equation term indices, product/accumulator width helpers,
// output saturation bounds and the MAC-state sequencing function.
// -----------------------------------------------------------------------------
package fan_ctrl_pkg;

    // MACn encodes as n+1 so a MAC state's value is also the index of the next term
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_MAC3 = 3'd4,
        ST_MAC4 = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam int unsigned N_TERMS = 5;
    localparam int unsigned TERM_B2 = 0;
    localparam int unsigned TERM_B1 = 1;
    localparam int unsigned TERM_B0 = 2;
    localparam int unsigned TERM_A1 = 3;
    localparam int unsigned TERM_A0 = 4;

    // Product of an (adc_w+1)-bit error/output and a coef_w-bit coefficient
    function automatic int unsigned prod_w(input int unsigned adc_w, input int unsigned coef_w);
        return adc_w + 1 + coef_w;
    endfunction

    function automatic int unsigned acc_w(input int unsigned adc_w, input int unsigned coef_w,
                                          input int unsigned guard);
        return prod_w(adc_w, coef_w) + guard;
    endfunction

    function automatic int sat_hi(input int unsigned adc_w);
        return (1 << adc_w) - 1;
    endfunction

    function automatic int sat_lo(input int unsigned adc_w);
        return -(1 << adc_w);
    endfunction

    // First MAC state at or after term index 'start' whose term is enabled, else DONE
    function automatic state_t next_mac(input logic [N_TERMS-1:0] nz, input logic [2:0] start);
        state_t s;
        s = ST_DONE;
        if (start <= 3'(TERM_A0) && nz[TERM_A0]) s = ST_MAC4;
        if (start <= 3'(TERM_A1) && nz[TERM_A1]) s = ST_MAC3;
        if (start <= 3'(TERM_B0) && nz[TERM_B0]) s = ST_MAC2;
        if (start <= 3'(TERM_B1) && nz[TERM_B1]) s = ST_MAC1;
        if (start <= 3'(TERM_B2) && nz[TERM_B2]) s = ST_MAC0;
        return s;
    endfunction

endpackage

// File: rtl/fan_pid_mac.sv
// -----------------------------------------------------------------------------
// fan_pid_mac
// Single signed multiplier feeding a wrapping accumulator.
// Ports: i_clk, i_rst (sync, active-high), i_clr (zero acc), i_en (acc += x*coef),
//        i_x (signed operand), i_coef (signed coefficient), o_acc (accumulator).
// -----------------------------------------------------------------------------
module fan_pid_mac #(
    parameter int unsigned X_W   = 5,
    parameter int unsigned C_W   = 9,
    parameter int unsigned ACC_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [X_W-1:0]   i_x,
    input  logic signed [C_W-1:0]   i_coef,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_c_ext;
    logic signed [ACC_W-1:0] w_prod;

    // Product taken modulo 2^ACC_W; the accumulator wraps by design
    assign w_x_ext = ACC_W'(i_x);
    assign w_c_ext = ACC_W'(i_coef);
    assign w_prod  = w_x_ext * w_c_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fan_pid_sequencer.sv
// -----------------------------------------------------------------------------
// fan_pid_sequencer
// Time-multiplexed PID step engine: divides clk_i down to the control tick,
// samples the error set_i-adc_i, evaluates
//   y = b2*x0 + b1*x1 + b0*x2 - a1*y1 - a0*y2
// on one shared MAC, rounds, saturates and publishes y_o with a valid_o pulse.
// Ports: clk_i, rst_i (sync, active-high), en_i (tick enable), adc_i/set_i
//        (unsigned samples), b2_i..a0_i (signed coefficients), clr_overrun_i;
//        y_o (signed output), valid_o, busy_o, overrun_o (sticky).
// Build option: define PID_SKIP_ZERO_COEF_EN to bypass MAC states whose
// coefficient is zero (latency = 2 + nonzero coefficients).
// -----------------------------------------------------------------------------
module fan_pid_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH  = 4,
    parameter int unsigned COEF_BITWIDTH = 8,
    parameter int unsigned FRAC_BITWIDTH = 6,
    parameter int unsigned ACC_GUARD     = 3,
    parameter int unsigned CLK_FREQ      = 1_000_000,
    parameter int unsigned PID_FREQ      = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    input  logic        [ADC_BITWIDTH-1:0]  adc_i,
    input  logic        [ADC_BITWIDTH-1:0]  set_i,
    input  logic signed [COEF_BITWIDTH-1:0] b2_i,
    input  logic signed [COEF_BITWIDTH-1:0] b1_i,
    input  logic signed [COEF_BITWIDTH-1:0] b0_i,
    input  logic signed [COEF_BITWIDTH-1:0] a1_i,
    input  logic signed [COEF_BITWIDTH-1:0] a0_i,
    input  logic                            clr_overrun_i,
    output logic signed [ADC_BITWIDTH:0]    y_o,
    output logic                            valid_o,
    output logic                            busy_o,
    output logic                            overrun_o
);

    localparam int unsigned TICK_DIV = CLK_FREQ / PID_FREQ;
    localparam int unsigned CNT_W    = $clog2(TICK_DIV);
    localparam int unsigned X_W      = ADC_BITWIDTH + 1;
    localparam int unsigned C_W      = COEF_BITWIDTH + 1;
    localparam int unsigned ACC_W    = acc_w(ADC_BITWIDTH, COEF_BITWIDTH, ACC_GUARD);

    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (FRAC_BITWIDTH - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(sat_hi(ADC_BITWIDTH));
    localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(sat_lo(ADC_BITWIDTH));

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [X_W-1:0]   r_x0, r_x1, r_x2, r_y1, r_y2, r_y;
    logic                    r_valid, r_busy, r_overrun;

    logic                    w_tick;
    logic signed [X_W-1:0]   w_err;
    logic [N_TERMS-1:0]      w_nz;
    logic                    w_mac_clr, w_mac_en;
    logic signed [X_W-1:0]   w_mac_x;
    logic signed [C_W-1:0]   w_mac_c;
    logic signed [ACC_W-1:0] w_acc, w_rnd, w_sh;
    logic signed [X_W-1:0]   w_ysat;

    assign w_tick = en_i && (r_cnt == '0);
    assign w_err  = $signed({1'b0, set_i}) - $signed({1'b0, adc_i});

`ifdef PID_SKIP_ZERO_COEF_EN
    assign w_nz = {a0_i != '0, a1_i != '0, b0_i != '0, b1_i != '0, b2_i != '0};
`else
    assign w_nz = '1;
`endif

    // Operand select; feedback coefficients are negated one bit wider so -(-2^(N-1)) is exact
    always_comb begin
        w_mac_en = 1'b0;
        w_mac_x  = '0;
        w_mac_c  = '0;
        case (r_state)
            ST_MAC0: begin w_mac_en = 1'b1; w_mac_x = r_x0; w_mac_c =  C_W'(b2_i); end
            ST_MAC1: begin w_mac_en = 1'b1; w_mac_x = r_x1; w_mac_c =  C_W'(b1_i); end
            ST_MAC2: begin w_mac_en = 1'b1; w_mac_x = r_x2; w_mac_c =  C_W'(b0_i); end
            ST_MAC3: begin w_mac_en = 1'b1; w_mac_x = r_y1; w_mac_c = -C_W'(a1_i); end
            ST_MAC4: begin w_mac_en = 1'b1; w_mac_x = r_y2; w_mac_c = -C_W'(a0_i); end
            default: ;
        endcase
    end

    assign w_mac_clr = (r_state == ST_IDLE) && w_tick;

    fan_pid_mac #(
        .X_W   (X_W),
        .C_W   (C_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_x    (w_mac_x),
        .i_coef (w_mac_c),
        .o_acc  (w_acc)
    );

    // Round half up, drop fraction bits, clamp to the output range
    assign w_rnd = w_acc + HALF_LSB;
    assign w_sh  = w_rnd >>> FRAC_BITWIDTH;

    always_comb begin
        w_ysat = X_W'(w_sh);
        if (w_sh > SAT_HI) begin
            w_ysat = X_W'(SAT_HI);
        end else if (w_sh < SAT_LO) begin
            w_ysat = X_W'(SAT_LO);
        end
    end

    // Tick divider, overrun flag and step sequencer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_W'(TICK_DIV - 1);
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if (en_i) begin
                r_cnt <= (r_cnt == '0) ? CNT_W'(TICK_DIV - 1) : r_cnt - CNT_W'(1);
            end

            // A new overrun takes priority over a clear in the same cycle
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun_i) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_x0    <= w_err;
                        r_busy  <= 1'b1;
                        r_state <= next_mac(w_nz, 3'd0);
                    end
                end
                ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3, ST_MAC4: begin
                    r_state <= next_mac(w_nz, 3'(r_state));
                end
                ST_DONE: begin
                    // Histories keep the clamped output, so the integrator cannot wind up
                    r_y     <= w_ysat;
                    r_y1    <= w_ysat;
                    r_y2    <= r_y1;
                    r_x1    <= r_x0;
                    r_x2    <= r_x1;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign y_o       = r_y;
    assign valid_o   = r_valid;
    assign busy_o    = r_busy;
    assign overrun_o = r_overrun;

endmodule
